// File: rtl/ahblite_uart_tx.sv
// AHB-Lite UART transmitter: CPU-fed TX FIFO serialised as 8N1 frames on TXD,
// with full-FIFO wait states, two-cycle ERROR responses and an empty interrupt.
module ahblite_uart_tx #(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA,
   output logic        TXD,
   output logic        IRQ
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_BAUD   = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

   logic          dphValid_q, dphWrite_q, err1_q, err2_q;
   logic [1:0]    dphAddr_q;
   logic [1:0]    ctrl_q;
   logic [15:0]   baudDiv_q;
   logic [7:0]    fifoMem_q [FIFO_DEPTH];
   logic [AW-1:0] wrPtr_q, rdPtr_q;
   logic [CW-1:0] count_q;
   txState_t      state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bitCnt_q, bitCnt_d;
   logic [15:0]   baudCnt_q, baudCnt_d;
   logic [15:0]   frameDiv_q, frameDiv_d;
   logic          txd_q, txd_d;
   logic          irq_q;

   logic addrPhase, illegal, fifoFull, fifoEmpty, dataWr, stall, wrDone;
   logic push, pop, canPop, txBusy;
   logic [31:0] statusWord;
   logic unusedBits;

   assign unusedBits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

   assign addrPhase = HSEL & HREADY & HTRANS[1];
   assign illegal   = (HSIZE != 3'b010) | (HWRITE & (HADDR[3:2] == ADDR_STATUS));
   assign fifoFull  = (count_q == CW'(FIFO_DEPTH));
   assign fifoEmpty = (count_q == '0);
   assign txBusy    = (state_q != IDLE);
   assign canPop    = ctrl_q[0] & ~fifoEmpty;

   // A DATA write into a full FIFO is held off; everything else completes at once.
   assign dataWr    = dphValid_q & dphWrite_q;
   assign stall     = dataWr & (dphAddr_q == ADDR_DATA) & fifoFull;
   assign wrDone    = dataWr & ~stall;
   assign push      = wrDone & (dphAddr_q == ADDR_DATA);

   assign HREADYOUT = ~err1_q & ~stall;
   assign HRESP     = err1_q | err2_q;
   assign TXD       = txd_q;
   assign IRQ       = irq_q;

   // Track the data phase of a legal transfer, or walk the two ERROR cycles for an illegal one.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dphValid_q <= 1'b0;
         dphWrite_q <= 1'b0;
         dphAddr_q  <= 2'd0;
         err1_q     <= 1'b0;
         err2_q     <= 1'b0;
      end else begin
         if (HREADY) begin
            dphValid_q <= addrPhase & ~illegal;
            dphWrite_q <= HWRITE;
            dphAddr_q  <= HADDR[3:2];
         end
         err1_q <= addrPhase & illegal;
         err2_q <= err1_q;
      end
   end

   // Configuration registers are written when their data phase completes.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ctrl_q    <= 2'b01;
         baudDiv_q <= DEFAULT_DIV;
      end else begin
         if (wrDone && dphAddr_q == ADDR_BAUD) baudDiv_q <= HWDATA[15:0];
         if (wrDone && dphAddr_q == ADDR_CTRL) ctrl_q <= HWDATA[1:0];
      end
   end

   // FIFO storage needs no reset; only the pointers and count define its contents.
   always_ff @(posedge HCLK) begin
      if (push) fifoMem_q[wrPtr_q] <= HWDATA[7:0];
   end

   // FIFO pointers wrap naturally; a simultaneous push and pop leaves the count alone.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + AW'(1);
         if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Transmitter state, shift register, bit timing and registered serial line.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= IDLE;
         shift_q    <= 8'd0;
         bitCnt_q   <= 3'd0;
         baudCnt_q  <= 16'd0;
         frameDiv_q <= 16'd0;
         txd_q      <= 1'b1;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bitCnt_q   <= bitCnt_d;
         baudCnt_q  <= baudCnt_d;
         frameDiv_q <= frameDiv_d;
         txd_q      <= txd_d;
         irq_q      <= ctrl_q[1] & fifoEmpty & ~txBusy;
      end
   end

   // Frame sequencing; the divider is sampled once per frame and a new frame may follow STOP directly.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bitCnt_d   = bitCnt_q;
      baudCnt_d  = baudCnt_q;
      frameDiv_d = frameDiv_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (canPop) begin
               pop        = 1'b1;
               shift_d    = fifoMem_q[rdPtr_q];
               baudCnt_d  = baudDiv_q;
               frameDiv_d = baudDiv_q;
               state_d    = START;
            end
         end
         START: begin
            if (baudCnt_q == 16'd0) begin
               baudCnt_d = frameDiv_q;
               bitCnt_d  = 3'd0;
               state_d   = DATA;
            end else begin
               baudCnt_d = baudCnt_q - 16'd1;
            end
         end
         DATA: begin
            if (baudCnt_q == 16'd0) begin
               baudCnt_d = frameDiv_q;
               if (bitCnt_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  shift_d  = {1'b0, shift_q[7:1]};
                  bitCnt_d = bitCnt_q + 3'd1;
               end
            end else begin
               baudCnt_d = baudCnt_q - 16'd1;
            end
         end
         STOP: begin
            if (baudCnt_q == 16'd0) begin
               if (canPop) begin
                  pop        = 1'b1;
                  shift_d    = fifoMem_q[rdPtr_q];
                  baudCnt_d  = baudDiv_q;
                  frameDiv_d = baudDiv_q;
                  state_d    = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baudCnt_d = baudCnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   // Read data is driven only during a legal read data phase.
   always_comb begin
      statusWord            = 32'd0;
      statusWord[0]         = txBusy;
      statusWord[1]         = fifoFull;
      statusWord[2]         = fifoEmpty;
      statusWord[8 +: CW]   = count_q;
      HRDATA                = 32'd0;
      if (dphValid_q && !dphWrite_q) begin
         case (dphAddr_q)
            ADDR_STATUS: HRDATA = statusWord;
            ADDR_BAUD:   HRDATA = {16'd0, baudDiv_q};
            ADDR_CTRL:   HRDATA = {30'd0, ctrl_q};
            default:     HRDATA = 32'd0;
         endcase
      end
   end
endmodule

// File: tb/tb_ahblite_uart_tx.sv
// Testbench for ahblite_uart_tx: AHB master tasks, a TXD frame decoder and
// scenario tasks comparing against expected bytes and register values.
module tb_ahblite_uart_tx;
   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        TXD;
   logic        IRQ;

   int assertions = 0;
   int failures   = 0;
   int tbPeriod   = 434;

   typedef struct {
      logic [7:0] data;
      bit         ok;
   } frame_t;
   frame_t rxQ[$];

   bit         monBusy = 1'b0;
   int         monCyc, monP, monK;
   logic [9:0] monBits;
   bit         monOk;
   frame_t     monFrame;

   ahblite_uart_tx dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .TXD(TXD), .IRQ(IRQ)
   );

   assign HREADY = HREADYOUT;

   // Free-running bus clock.
   always #5 HCLK = ~HCLK;

   // Decode TXD into frames: every bit must hold for tbPeriod cycles, start 0, stop 1.
   initial begin
      forever begin
         @(negedge HCLK);
         if (!HRESETn) begin
            monBusy = 1'b0;
         end else if (!monBusy) begin
            if (TXD === 1'b0) begin
               monBusy = 1'b1;
               monP    = tbPeriod;
               monCyc  = 1;
               monBits = 10'd0;
               monOk   = 1'b1;
               if (monP == 1) monCyc = 1;
            end
         end else begin
            monK = monCyc / monP;
            if (monCyc % monP == 0) monBits[monK] = TXD;
            else if (monBits[monK] !== TXD) monOk = 1'b0;
            monCyc++;
            if (monCyc == 10 * monP) begin
               if (monBits[0] !== 1'b0 || monBits[9] !== 1'b1) monOk = 1'b0;
               monFrame.data = monBits[8:1];
               monFrame.ok   = monOk;
               rxQ.push_back(monFrame);
               monBusy = 1'b0;
            end
         end
      end
   end

   task automatic ahbXfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int waits,
                          output logic firstRdy, output logic firstResp, output logic lastResp);
      @(negedge HCLK);
      HSEL = 1'b1; HADDR = addr; HTRANS = 2'b10; HWRITE = wr; HSIZE = size;
      @(posedge HCLK);
      #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wdata;
      waits = 0;
      @(negedge HCLK);
      firstRdy  = HREADYOUT;
      firstResp = HRESP;
      while (HREADYOUT !== 1'b1 && waits < 5000) begin
         waits++;
         @(negedge HCLK);
      end
      if (HREADYOUT !== 1'b1) begin
         assertions++;
         failures++;
         $display("[TB] FAIL bus_timeout: HREADYOUT=%b after %0d cycles, required 1", HREADYOUT, waits);
         $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
         $fatal(1, "[TB] bus hung");
      end
      rdata    = HRDATA;
      lastResp = HRESP;
      @(posedge HCLK);
      #1;
   endtask

   task automatic ahbWrite(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] rd;
      int          w;
      logic        fr, fp, lp;
      ahbXfer(1'b1, addr, 3'b010, data, rd, w, fr, fp, lp);
   endtask

   task automatic ahbRead(input logic [31:0] addr, output logic [31:0] data);
      int   w;
      logic fr, fp, lp;
      ahbXfer(1'b0, addr, 3'b010, 32'd0, data, w, fr, fp, lp);
   endtask

   task automatic waitFrames(input int n, input int budget, output bit timedOut);
      int c = 0;
      while (rxQ.size() < n && c < budget) begin
         @(negedge HCLK);
         c++;
      end
      timedOut = (rxQ.size() < n);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HSIZE = 3'b010;
      HWRITE = 1'b0; HWDATA = 32'd0;
      repeat (3) @(negedge HCLK);
      assertions++;
      if ({HREADYOUT, HRESP, TXD, IRQ} !== 4'b1010 || HRDATA !== 32'd0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: rdy/resp/txd/irq=%b hrdata=%h, required 1010 / 0", {HREADYOUT, HRESP, TXD, IRQ}, HRDATA);
      end
      HRESETn = 1'b1;
      ahbRead(32'h4, rd);
      assertions++;
      if (rd !== 32'h0000_0004) begin failures++; $display("[TB] FAIL reset_status: got %h required %h", rd, 32'h4); end
      ahbRead(32'h8, rd);
      assertions++;
      if (rd !== 32'h0000_01B1) begin failures++; $display("[TB] FAIL reset_bauddiv: got %h required %h", rd, 32'h1B1); end
      ahbRead(32'hC, rd);
      assertions++;
      if (rd !== 32'h0000_0001) begin failures++; $display("[TB] FAIL reset_ctrl: got %h required %h", rd, 32'h1); end
      assertions++;
      if (TXD !== 1'b1 || IRQ !== 1'b0) begin failures++; $display("[TB] FAIL reset_lines: txd=%b irq=%b required 1 0", TXD, IRQ); end
   endtask

   task automatic test_single_frame();
      logic [31:0] rd;
      bit          to;
      frame_t      f;
      ahbWrite(32'h8, 32'd3);
      tbPeriod = 4;
      ahbWrite(32'h0, 32'h0000_00A5);
      ahbRead(32'h4, rd);
      assertions++;
      if (rd !== 32'h0000_0005) begin failures++; $display("[TB] FAIL frame_busy_status: got %h required %h", rd, 32'h5); end
      waitFrames(1, 200, to);
      assertions++;
      if (to) begin
         failures++; $display("[TB] FAIL frame_a5_seen: frames=%0d required 1", rxQ.size());
      end else begin
         f = rxQ.pop_front();
         if (f.data !== 8'hA5 || !f.ok) begin
            failures++; $display("[TB] FAIL frame_a5: got %h timing_ok=%0d required a5 1", f.data, f.ok);
         end
      end
      ahbRead(32'h4, rd);
      assertions++;
      if (rd !== 32'h0000_0004) begin failures++; $display("[TB] FAIL frame_idle_status: got %h required %h", rd, 32'h4); end
   endtask

   task automatic test_fifo_full();
      logic [31:0] rd;
      logic [7:0]  expQ[$];
      logic [7:0]  b;
      int          w;
      logic        fr, fp, lp;
      bit          to;
      frame_t      f;
      ahbWrite(32'h8, 32'd3);
      tbPeriod = 4;
      ahbWrite(32'hC, 32'd0);
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         expQ.push_back(b);
         ahbWrite(32'h0, {24'd0, b});
      end
      ahbRead(32'h4, rd);
      assertions++;
      if (rd !== 32'h0000_0802) begin failures++; $display("[TB] FAIL full_status: got %h required %h", rd, 32'h802); end
      ahbWrite(32'hC, 32'd1);
      b = 8'($urandom);
      expQ.push_back(b);
      ahbWrite(32'h0, {24'd0, b});
      b = 8'($urandom);
      expQ.push_back(b);
      ahbXfer(1'b1, 32'h0, 3'b010, {24'd0, b}, rd, w, fr, fp, lp);
      assertions++;
      if (fr !== 1'b0 || w < 1 || lp !== 1'b0) begin
         failures++; $display("[TB] FAIL full_stall: first_ready=%b waits=%0d resp=%b required 0 >=1 0", fr, w, lp);
      end
      ahbRead(32'h4, rd);
      assertions++;
      if (rd !== 32'h0000_0803) begin failures++; $display("[TB] FAIL full_after_stall: got %h required %h", rd, 32'h803); end
      waitFrames(10, 1000, to);
      assertions++;
      if (to) begin failures++; $display("[TB] FAIL full_drain: frames=%0d required 10", rxQ.size()); end
      for (int i = 0; i < 10; i++) begin
         assertions++;
         if (rxQ.size() == 0) begin
            failures++; $display("[TB] FAIL full_frame%0d: missing, required %h", i, expQ[i]);
         end else begin
            f = rxQ.pop_front();
            if (f.data !== expQ[i] || !f.ok) begin
               failures++; $display("[TB] FAIL full_frame%0d: got %h timing_ok=%0d required %h 1", i, f.data, f.ok, expQ[i]);
            end
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] rd;
      int          w;
      logic        fr, fp, lp;
      ahbWrite(32'h8, 32'd5);
      tbPeriod = 6;
      ahbXfer(1'b1, 32'h4, 3'b010, 32'hFFFF_FFFF, rd, w, fr, fp, lp);
      assertions++;
      if ({fr, fp, lp} !== 3'b011 || w != 1) begin
         failures++; $display("[TB] FAIL err_status_write: rdy1/resp1/resp2=%b waits=%0d required 011 1", {fr, fp, lp}, w);
      end
      ahbXfer(1'b1, 32'h8, 3'b000, 32'h0000_0077, rd, w, fr, fp, lp);
      assertions++;
      if ({fr, fp, lp} !== 3'b011 || w != 1) begin
         failures++; $display("[TB] FAIL err_byte_write: rdy1/resp1/resp2=%b waits=%0d required 011 1", {fr, fp, lp}, w);
      end
      ahbXfer(1'b0, 32'h8, 3'b010, 32'd0, rd, w, fr, fp, lp);
      assertions++;
      if (rd !== 32'd5 || lp !== 1'b0) begin failures++; $display("[TB] FAIL err_baud_kept: got %h resp=%b required 5 0", rd, lp); end
      ahbXfer(1'b1, 32'h0, 3'b001, 32'h0000_00C3, rd, w, fr, fp, lp);
      assertions++;
      if ({fr, fp, lp} !== 3'b011) begin failures++; $display("[TB] FAIL err_half_data: rdy1/resp1/resp2=%b required 011", {fr, fp, lp}); end
      ahbXfer(1'b0, 32'hC, 3'b000, 32'd0, rd, w, fr, fp, lp);
      assertions++;
      if ({fr, fp, lp} !== 3'b011 || rd !== 32'd0) begin
         failures++; $display("[TB] FAIL err_byte_read: rdy1/resp1/resp2=%b data=%h required 011 0", {fr, fp, lp}, rd);
      end
      ahbRead(32'h4, rd);
      assertions++;
      if (rd !== 32'h0000_0004) begin failures++; $display("[TB] FAIL err_fifo_kept: got %h required %h", rd, 32'h4); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic [7:0]  b0, b1, b2;
      int          c, idx;
      bit          to;
      frame_t      f;
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
      ahbWrite(32'h8, 32'd0);
      tbPeriod = 1;
      ahbWrite(32'hC, 32'd3);
      repeat (2) @(negedge HCLK);
      assertions++;
      if (IRQ !== 1'b1) begin failures++; $display("[TB] FAIL irq_empty_idle: got %b required 1", IRQ); end
      idx = 0;
      fork
         begin
            ahbWrite(32'h0, {24'd0, b0});
            ahbWrite(32'h0, {24'd0, b1});
         end
         begin
            c = 0;
            do begin @(negedge HCLK); c++; end while (TXD !== 1'b0 && c < 200);
            while (IRQ !== 1'b1 && idx < 100) begin @(negedge HCLK); idx++; end
         end
      join
      assertions++;
      if (idx != 21) begin failures++; $display("[TB] FAIL b2b_irq_timing: irq rose %0d cycles after first start, required 21", idx); end
      waitFrames(2, 100, to);
      for (int i = 0; i < 2; i++) begin
         assertions++;
         if (rxQ.size() == 0) begin
            failures++; $display("[TB] FAIL b2b_frame%0d: missing", i);
         end else begin
            f = rxQ.pop_front();
            if (f.data !== (i == 0 ? b0 : b1) || !f.ok) begin
               failures++; $display("[TB] FAIL b2b_frame%0d: got %h timing_ok=%0d required %h 1", i, f.data, f.ok, (i == 0 ? b0 : b1));
            end
         end
      end
      ahbWrite(32'h0, {24'd0, b2});
      @(negedge HCLK);
      assertions++;
      if (IRQ !== 1'b1) begin failures++; $display("[TB] FAIL irq_registered: got %b required 1", IRQ); end
      @(negedge HCLK);
      assertions++;
      if (IRQ !== 1'b0) begin failures++; $display("[TB] FAIL irq_clear_on_push: got %b required 0", IRQ); end
      waitFrames(1, 100, to);
      assertions++;
      if (to) begin
         failures++; $display("[TB] FAIL b2b_third: frames=%0d required 1", rxQ.size());
      end else begin
         f = rxQ.pop_front();
         if (f.data !== b2 || !f.ok) begin failures++; $display("[TB] FAIL b2b_third: got %h required %h", f.data, b2); end
      end
      ahbWrite(32'hC, 32'd1);
      repeat (2) @(negedge HCLK);
      assertions++;
      if (IRQ !== 1'b0) begin failures++; $display("[TB] FAIL irq_disabled: got %b required 0", IRQ); end
      ahbRead(32'hC, rd);
      assertions++;
      if (rd !== 32'd1) begin failures++; $display("[TB] FAIL ctrl_readback: got %h required 1", rd); end
   endtask

   task automatic test_random();
      logic [31:0] rd, wv;
      logic [7:0]  expQ[$];
      logic [7:0]  b;
      int          div, n;
      bit          to;
      frame_t      f;
      for (int r = 0; r < 5; r++) begin
         div = int'($urandom_range(0, 4));
         wv  = {16'($urandom), 16'(div)};
         ahbWrite(32'h8, wv);
         tbPeriod = div + 1;
         ahbRead(32'h8, rd);
         assertions++;
         if (rd !== {16'd0, wv[15:0]}) begin failures++; $display("[TB] FAIL rand_baud%0d: got %h required %h", r, rd, {16'd0, wv[15:0]}); end
         n = int'($urandom_range(1, 5));
         expQ.delete();
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            expQ.push_back(b);
            ahbWrite(32'h0, {$urandom, b} >> 0 & 32'h0000_00FF | (32'($urandom) & 32'hFFFF_FF00));
         end
         waitFrames(n, n * 10 * (div + 1) + 200, to);
         for (int i = 0; i < n; i++) begin
            assertions++;
            if (rxQ.size() == 0) begin
               failures++; $display("[TB] FAIL rand%0d_frame%0d: missing, required %h", r, i, expQ[i]);
            end else begin
               f = rxQ.pop_front();
               if (f.data !== expQ[i] || !f.ok) begin
                  failures++; $display("[TB] FAIL rand%0d_frame%0d: got %h timing_ok=%0d required %h 1", r, i, f.data, f.ok, expQ[i]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] rd;
      int          c;
      ahbWrite(32'h8, 32'd9);
      tbPeriod = 10;
      ahbWrite(32'h0, 32'h0000_0000);
      ahbWrite(32'h0, 32'h0000_005A);
      c = 0;
      while (TXD !== 1'b0 && c < 100) begin @(negedge HCLK); c++; end
      repeat (25) @(negedge HCLK);
      assertions++;
      if (TXD !== 1'b0) begin failures++; $display("[TB] FAIL midframe_low: txd=%b required 0", TXD); end
      #2;
      HRESETn = 1'b0;
      #1;
      assertions++;
      if ({TXD, HREADYOUT, HRESP, IRQ} !== 4'b1100) begin
         failures++; $display("[TB] FAIL midframe_reset: txd/rdy/resp/irq=%b required 1100", {TXD, HREADYOUT, HRESP, IRQ});
      end
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      rxQ.delete();
      tbPeriod = 434;
      ahbRead(32'h4, rd);
      assertions++;
      if (rd !== 32'h0000_0004) begin failures++; $display("[TB] FAIL midframe_status: got %h required %h", rd, 32'h4); end
      ahbRead(32'h8, rd);
      assertions++;
      if (rd !== 32'd433) begin failures++; $display("[TB] FAIL midframe_baud: got %h required %h", rd, 32'd433); end
      repeat (20) @(negedge HCLK);
      assertions++;
      if (rxQ.size() != 0 || TXD !== 1'b1) begin
         failures++; $display("[TB] FAIL midframe_quiet: frames=%0d txd=%b required 0 1", rxQ.size(), TXD);
      end
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_single_frame();
      test_fifo_full();
      test_illegal();
      test_back_to_back();
      test_random();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
